// File: rtl/rf_pkg.sv
// Shared types and default sizes for the multi-port register file.
package rf_pkg;

   localparam int RF_XLEN  = 32;
   localparam int RF_DEPTH = 32;
   localparam int RF_NRD   = 2;

   typedef enum logic [0:0] {
      RF_IDLE  = 1'b0,
      RF_CLEAR = 1'b1
   } rf_state_t;

endpackage

// File: rtl/reg_file_mp_if.sv
// Bus between issue/writeback logic and the register file.
interface reg_file_mp_if
   import rf_pkg::*;
#(
   parameter int XLEN  = RF_XLEN,
   parameter int DEPTH = RF_DEPTH,
   parameter int NRD   = RF_NRD
);
   localparam int AW = $clog2(DEPTH);

   logic [NRD*AW-1:0]   rd_addr;
   logic [NRD*XLEN-1:0] rd_data;
   logic [NRD-1:0]      rd_pend;
   logic                wr_en;
   logic [AW-1:0]       wr_addr;
   logic [XLEN-1:0]     wr_data;
   logic                iss_en;
   logic [AW-1:0]       iss_addr;
   logic                clr_req;
   logic                clr_busy;

   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, clr_req,
      input  rd_data, rd_pend, clr_busy
   );

   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, iss_en, iss_addr, clr_req,
      output rd_data, rd_pend, clr_busy
   );

endinterface

// File: rtl/rf_read_port.sv
// One registered read port: decode, zero-register, write bypass, pending mask.
module rf_read_port
   import rf_pkg::*;
#(
   parameter int XLEN     = RF_XLEN,
   parameter int DEPTH    = RF_DEPTH,
   parameter bit BYPASS   = 1'b1,
   parameter bit ZERO_REG = 1'b1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic [AW-1:0]              addr,
   input  logic [DEPTH-1:0][XLEN-1:0] regs,
   input  logic [DEPTH-1:0]           pend,
   input  logic                       wr_legal,
   input  logic [AW-1:0]              wr_addr,
   input  logic [XLEN-1:0]            wr_data,
   output logic [XLEN-1:0]            rd_data,
   output logic                       rd_pend
);

   logic is_zero;
   logic wr_hit;

   assign is_zero = ZERO_REG && (addr == '0);
   assign wr_hit  = wr_legal && (wr_addr == addr);

   // Capture read data and pending flag for the presented address.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= '0;
         rd_pend <= 1'b0;
      end else begin
         if (is_zero)
            rd_data <= '0;
         else if (BYPASS && wr_hit)
            rd_data <= wr_data;
         else
            rd_data <= regs[addr];
         // a write retires the pending producer regardless of bypass
         rd_pend <= is_zero ? 1'b0 : (wr_hit ? 1'b0 : pend[addr]);
      end
   end

endmodule

// File: rtl/reg_file_mp.sv
// Multi-read-port register file with pending scoreboard and clear sequencer.
module reg_file_mp
   import rf_pkg::*;
#(
   parameter int XLEN     = RF_XLEN,
   parameter int DEPTH    = RF_DEPTH,
   parameter int NRD      = RF_NRD,
   parameter bit BYPASS   = 1'b1,
   parameter bit ZERO_REG = 1'b1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic         clk,
   input  logic         rst,
   reg_file_mp_if.slave bus
);

   rf_state_t                 state;
   logic [AW-1:0]             idx;
   logic [DEPTH-1:0][XLEN-1:0] regs;
   logic [DEPTH-1:0]          pend;
   logic [DEPTH-1:0]          pend_next;
   logic                      wr_legal;
   logic                      iss_legal;
   logic [XLEN-1:0]           rd_data_arr [NRD];
   logic                      rd_pend_arr [NRD];

   assign wr_legal  = bus.wr_en && (state == RF_IDLE) &&
                      !(ZERO_REG && (bus.wr_addr == '0));
   assign iss_legal = bus.iss_en && (state == RF_IDLE) &&
                      !(ZERO_REG && (bus.iss_addr == '0));
   assign bus.clr_busy = (state == RF_CLEAR);

   // Clear sequencer: walk idx over every register once, then return to idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= RF_IDLE;
         idx   <= '0;
      end else begin
         case (state)
            RF_IDLE: begin
               if (bus.clr_req) begin
                  state <= RF_CLEAR;
                  idx   <= '0;
               end
            end
            RF_CLEAR: begin
               idx <= idx + 1'b1;
               if (idx == AW'(DEPTH - 1))
                  state <= RF_IDLE;
            end
            default: state <= RF_IDLE;
         endcase
      end
   end

   // Register array: clear engine owns the write path while it runs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         regs <= '0;
      else if (state == RF_CLEAR)
         regs[idx] <= '0;
      else if (wr_legal)
         regs[bus.wr_addr] <= bus.wr_data;
   end

   // Next pending vector; a same-cycle issue beats the write's clear.
   always_comb begin
      pend_next = pend;
      if (state == RF_CLEAR) begin
         pend_next[idx] = 1'b0;
      end else begin
         if (wr_legal)
            pend_next[bus.wr_addr] = 1'b0;
         if (iss_legal)
            pend_next[bus.iss_addr] = 1'b1;
      end
   end

   // Pending scoreboard storage.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         pend <= '0;
      else
         pend <= pend_next;
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      rf_read_port #(
         .XLEN     (XLEN),
         .DEPTH    (DEPTH),
         .BYPASS   (BYPASS),
         .ZERO_REG (ZERO_REG)
      ) u_rd (
         .clk      (clk),
         .rst      (rst),
         .addr     (bus.rd_addr[p*AW +: AW]),
         .regs     (regs),
         .pend     (pend),
         .wr_legal (wr_legal),
         .wr_addr  (bus.wr_addr),
         .wr_data  (bus.wr_data),
         .rd_data  (rd_data_arr[p]),
         .rd_pend  (rd_pend_arr[p])
      );
   end

   // Pack per-port results onto the bus.
   always_comb begin
      bus.rd_data = '0;
      bus.rd_pend = '0;
      for (int p = 0; p < NRD; p++) begin
         bus.rd_data[p*XLEN +: XLEN] = rd_data_arr[p];
         bus.rd_pend[p]              = rd_pend_arr[p];
      end
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench: two register files (bypass on/off) driven in lockstep, scoreboarded.
module tb_reg_file_mp;

   localparam int XLEN  = 32;
   localparam int DEPTH = 32;
   localparam int NRD   = 2;

   typedef struct {
      logic [1:0][31:0] d1;
      logic [1:0][31:0] d0;
      logic [1:0]       pd;
      logic             busy;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   exp_t q[$];

   logic [31:0] mreg  [DEPTH];
   bit          mpend [DEPTH];
   bit          mbusy;
   int          midx;

   reg_file_mp_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NRD(NRD)) bus1 ();
   reg_file_mp_if #(.XLEN(XLEN), .DEPTH(DEPTH), .NRD(NRD)) bus0 ();

   reg_file_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NRD(NRD), .BYPASS(1'b1), .ZERO_REG(1'b1))
      u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
   reg_file_mp #(.XLEN(XLEN), .DEPTH(DEPTH), .NRD(NRD), .BYPASS(1'b0), .ZERO_REG(1'b1))
      u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < DEPTH; i++) begin
         mreg[i]  = '0;
         mpend[i] = 1'b0;
      end
      mbusy = 1'b0;
      midx  = 0;
   endtask

   // One clock of stimulus; expected post-edge outputs go to the scoreboard.
   task automatic step(input bit we, input int wa, input logic [31:0] wd,
                       input bit ie, input int ia, input bit clr,
                       input int a0, input int a1);
      exp_t e;
      int   ad [2];
      bit   wl, il;
      @(negedge clk);
      bus1.wr_en = we;  bus1.wr_addr = 5'(wa); bus1.wr_data = wd;
      bus1.iss_en = ie; bus1.iss_addr = 5'(ia); bus1.clr_req = clr;
      bus1.rd_addr = {5'(a1), 5'(a0)};
      bus0.wr_en = we;  bus0.wr_addr = 5'(wa); bus0.wr_data = wd;
      bus0.iss_en = ie; bus0.iss_addr = 5'(ia); bus0.clr_req = clr;
      bus0.rd_addr = {5'(a1), 5'(a0)};
      ad[0] = a0;
      ad[1] = a1;
      wl = we && !mbusy && (wa != 0);
      il = ie && !mbusy && (ia != 0);
      for (int p = 0; p < 2; p++) begin
         if (ad[p] == 0) begin
            e.d1[p] = '0; e.d0[p] = '0; e.pd[p] = 1'b0;
         end else begin
            e.d0[p] = mreg[ad[p]];
            e.d1[p] = (wl && wa == ad[p]) ? wd : mreg[ad[p]];
            e.pd[p] = (wl && wa == ad[p]) ? 1'b0 : mpend[ad[p]];
         end
      end
      if (mbusy) begin
         mreg[midx]  = '0;
         mpend[midx] = 1'b0;
         midx++;
         if (midx == DEPTH) mbusy = 1'b0;
      end else begin
         if (wl) begin
            mreg[wa]  = wd;
            mpend[wa] = 1'b0;
         end
         if (il) mpend[ia] = 1'b1;
         if (clr) begin
            mbusy = 1'b1;
            midx  = 0;
         end
      end
      e.busy = mbusy;
      q.push_back(e);
   endtask

   task automatic idle(input int a0, input int a1);
      step(1'b0, 0, 32'h0, 1'b0, 0, 1'b0, a0, a1);
   endtask

   // Count busy cycles after a clr_req step, checking the duration.
   task automatic clear_and_count(input string nm, input int a0, input int a1);
      int cnt = 0;
      step(1'b0, 0, 32'h0, 1'b0, 0, 1'b1, a0, a1);
      @(posedge clk); #1;
      if (bus1.clr_busy) cnt++;
      for (int i = 0; i < 40; i++) begin
         if (i == 3) step(1'b1, 2, 32'h0000_0055, 1'b1, 2, 1'b0, 2, a1);
         else        idle(a0, a1);
         @(posedge clk); #1;
         if (bus1.clr_busy) cnt++;
      end
      chk(nm, 32'(cnt), 32'(DEPTH));
   endtask

   // Monitor: pop one expectation per edge that has one and compare.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            for (int p = 0; p < 2; p++) begin
               chk($sformatf("rd_data_byp1_p%0d", p), bus1.rd_data[p*XLEN +: XLEN], e.d1[p]);
               chk($sformatf("rd_data_byp0_p%0d", p), bus0.rd_data[p*XLEN +: XLEN], e.d0[p]);
               chk($sformatf("rd_pend_byp1_p%0d", p), 32'(bus1.rd_pend[p]), 32'(e.pd[p]));
               chk($sformatf("rd_pend_byp0_p%0d", p), 32'(bus0.rd_pend[p]), 32'(e.pd[p]));
            end
            chk("clr_busy_byp1", 32'(bus1.clr_busy), 32'(e.busy));
            chk("clr_busy_byp0", 32'(bus0.clr_busy), 32'(e.busy));
         end
      end
   end

   initial begin
      bus1.wr_en = 0; bus1.wr_addr = 0; bus1.wr_data = 0; bus1.iss_en = 0;
      bus1.iss_addr = 0; bus1.clr_req = 0; bus1.rd_addr = 0;
      bus0.wr_en = 0; bus0.wr_addr = 0; bus0.wr_data = 0; bus0.iss_en = 0;
      bus0.iss_addr = 0; bus0.clr_req = 0; bus0.rd_addr = 0;
      model_reset();
      repeat (2) @(negedge clk);
      chk("reset_data", bus1.rd_data, 64'h0);
      chk("reset_busy", 32'(bus1.clr_busy), 32'h0);
      rst = 1'b0;

      idle(5, 31);
      step(1'b1, 3, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, 1, 2);
      idle(3, 3);
      step(1'b1, 0, 32'h0000_1234, 1'b1, 0, 1'b0, 0, 3);
      idle(0, 0);
      step(1'b1, 7, 32'hA5A5_A5A5, 1'b0, 0, 1'b0, 3, 7);
      idle(7, 7);
      step(1'b0, 0, 32'h0, 1'b1, 9, 1'b0, 9, 1);
      idle(9, 9);
      step(1'b1, 9, 32'h0000_0909, 1'b0, 0, 1'b0, 9, 9);
      idle(9, 9);
      step(1'b1, 4, 32'hC0DE_0004, 1'b1, 4, 1'b0, 4, 1);
      idle(4, 4);

      for (int i = 1; i < DEPTH; i++)
         step(1'b1, i, 32'(i), (i % 3) == 0, i, 1'b0, i - 1, i);
      idle(3, 6);
      clear_and_count("clear_len", 1, 30);
      for (int i = 0; i < DEPTH; i += 2) idle(i, i + 1);

      for (int n = 0; n < 400; n++)
         step($urandom_range(0, 1) == 1, $urandom_range(0, DEPTH - 1), $urandom,
              $urandom_range(0, 2) == 0, $urandom_range(0, DEPTH - 1),
              $urandom_range(0, 99) == 0,
              $urandom_range(0, DEPTH - 1), $urandom_range(0, DEPTH - 1));
      while (mbusy) idle(1, 2);

      step(1'b1, 20, 32'h2020_2020, 1'b1, 21, 1'b0, 20, 21);
      step(1'b0, 0, 32'h0, 1'b0, 0, 1'b1, 20, 21);
      for (int i = 0; i < 10; i++) idle(20, 21);
      @(negedge clk);
      #2 rst = 1'b1;
      model_reset();
      #1;
      chk("rst_mid_busy1", 32'(bus1.clr_busy), 32'h0);
      chk("rst_mid_busy0", 32'(bus0.clr_busy), 32'h0);
      chk("rst_mid_data1", bus1.rd_data[31:0], 32'h0);
      chk("rst_mid_data0", bus0.rd_data[31:0], 32'h0);
      chk("rst_mid_pend1", 32'(bus1.rd_pend), 32'h0);
      @(negedge clk);
      rst = 1'b0;
      idle(20, 21);
      clear_and_count("clear_len_after_rst", 5, 31);
      idle(2, 31);

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
